// File: rtl/buffer_pkgs.sv
// Shared types for the rename/retire buffers: physical register width and
// the reorder-buffer entry layout.
package buffer_pkgs;

  parameter int PREG_W = 6;

  typedef struct packed {
    logic              valid;
    logic              completed;
    logic              has_dest;
    logic [4:0]        arch_rd;
    logic [PREG_W-1:0] dest_preg;
    logic [PREG_W-1:0] old_preg;
    logic [31:0]       pc;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order dispatch at the tail, out-of-order completion by
// index, in-order commit from the head, single-cycle flush.
// Optional feature macro: ROB_WB_BYPASS_EN -- a completion strobe aimed at a
// valid head makes that head committable in the same cycle.
module reorder_buffer
  import buffer_pkgs::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     disp_valid_i,
  output logic                     disp_ready_o,
  input  logic [31:0]              disp_pc_i,
  input  logic                     disp_has_dest_i,
  input  logic [4:0]               disp_arch_rd_i,
  input  logic [PREG_W-1:0]        disp_dest_preg_i,
  input  logic [PREG_W-1:0]        disp_old_preg_i,
  output logic [$clog2(DEPTH)-1:0] disp_index_o,
  input  logic                     wb_valid_i,
  input  logic [$clog2(DEPTH)-1:0] wb_index_i,
  input  logic                     flush_i,
  output logic                     rob_commit_valid_o,
  output rob_entry_t               rob_commit_entry_o,
  output logic [$clog2(DEPTH)-1:0] rob_commit_index_o,
  input  logic                     rob_commit_ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int IDX_W = $clog2(DEPTH);

  // Control state (reset)
  logic [IDX_W-1:0] head_q;
  logic [IDX_W-1:0] tail_q;
  logic [IDX_W:0]   count_q;
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] comp_q;

  // Payload storage (never reset; only meaningful where valid_q is set)
  logic [31:0]       pc_q       [DEPTH];
  logic              has_dest_q [DEPTH];
  logic [4:0]        arch_rd_q  [DEPTH];
  logic [PREG_W-1:0] dest_q     [DEPTH];
  logic [PREG_W-1:0] old_q      [DEPTH];

  logic head_done;
  logic disp_fire;
  logic commit_fire;

  // Count never exceeds DEPTH, so its MSB alone marks a full buffer.
  assign disp_ready_o = !count_q[IDX_W] && !flush_i;
  assign disp_fire    = disp_valid_i && disp_ready_o;
  assign disp_index_o = tail_q;
  assign count_o      = count_q;

`ifdef ROB_WB_BYPASS_EN
  assign head_done = comp_q[head_q] || (wb_valid_i && (wb_index_i == head_q));
`else
  assign head_done = comp_q[head_q];
`endif

  assign rob_commit_valid_o = valid_q[head_q] && head_done && !flush_i;
  assign rob_commit_index_o = head_q;
  assign commit_fire        = rob_commit_valid_o && rob_commit_ready_i;

  // Present the head entry combinationally, whether or not it is committable.
  always_comb begin
    rob_commit_entry_o           = '0;
    rob_commit_entry_o.valid     = valid_q[head_q];
    rob_commit_entry_o.completed = head_done;
    rob_commit_entry_o.has_dest  = has_dest_q[head_q];
    rob_commit_entry_o.arch_rd   = arch_rd_q[head_q];
    rob_commit_entry_o.dest_preg = dest_q[head_q];
    rob_commit_entry_o.old_preg  = old_q[head_q];
    rob_commit_entry_o.pc        = pc_q[head_q];
  end

  // Pointers, occupancy and per-entry status; reset beats flush beats the rest.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      comp_q  <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      comp_q  <= '0;
    end else begin
      // Completion is applied first so a same-cycle commit of the head wins.
      if (wb_valid_i && valid_q[wb_index_i]) begin
        comp_q[wb_index_i] <= 1'b1;
      end
      if (disp_fire) begin
        valid_q[tail_q] <= 1'b1;
        comp_q[tail_q]  <= 1'b0;
        tail_q          <= tail_q + 1'b1;
      end
      if (commit_fire) begin
        valid_q[head_q] <= 1'b0;
        comp_q[head_q]  <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      case ({disp_fire, commit_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Capture dispatched instruction fields into the tail slot.
  always_ff @(posedge clk_i) begin
    if (disp_fire) begin
      pc_q[tail_q]       <= disp_pc_i;
      has_dest_q[tail_q] <= disp_has_dest_i;
      arch_rd_q[tail_q]  <= disp_arch_rd_i;
      dest_q[tail_q]     <= disp_dest_preg_i;
      old_q[tail_q]      <= disp_old_preg_i;
    end
  end

endmodule
